// File: rtl/arf_retire_sched.sv
// In-order DEPTH-entry queue that serializes a 2-wide retire stream onto one ARF write port.
// Latency 1 cycle from accept to write; in_ready (count <= DEPTH-2) throttles both lanes together; the ARF never stalls.
module arf_retire_sched #(
    parameter int NUM_REG      = 32,
    parameter int NUM_REG_LOG2 = $clog2(NUM_REG),
    parameter int REG_SIZE     = 32,
    parameter int DEPTH        = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       lane0_valid,
    input  logic [NUM_REG_LOG2-1:0]    lane0_reg,
    input  logic [REG_SIZE-1:0]        lane0_data,
    input  logic                       lane1_valid,
    input  logic [NUM_REG_LOG2-1:0]    lane1_reg,
    input  logic [REG_SIZE-1:0]        lane1_data,
    output logic                       in_ready,
    output logic                       retire_valid,
    output logic [NUM_REG_LOG2-1:0]    retire_reg,
    output logic [REG_SIZE-1:0]        retire_reg_data,
    output logic [NUM_REG-1:0]         pending_mask,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       idle
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    typedef struct packed {
        logic [NUM_REG_LOG2-1:0] rd;
        logic [REG_SIZE-1:0]     dat;
    } entry_t;

    entry_t             mem [DEPTH];
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [CNT_W-1:0]   cnt;
    logic               push0;
    logic               push1;
    logic               pop;
    logic [PTR_W-1:0]   slot1;

    // Space for two entries is judged on registered occupancy only, so a full
    // pair always fits even without the same-cycle pop.
    assign in_ready = (cnt <= CNT_W'(DEPTH - 2));
    assign push0    = in_ready && lane0_valid && (lane0_reg != '0);
    assign push1    = in_ready && lane1_valid && (lane1_reg != '0);
    assign pop      = (cnt != '0);
    assign slot1    = wr_ptr + PTR_W'(push0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            rd_ptr <= rd_ptr + PTR_W'(pop);
            wr_ptr <= wr_ptr + PTR_W'(push0) + PTR_W'(push1);
            cnt    <= cnt + CNT_W'(push0) + CNT_W'(push1) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push0) mem[wr_ptr] <= '{rd: lane0_reg, dat: lane0_data};
        if (push1) mem[slot1]  <= '{rd: lane1_reg, dat: lane1_data};
    end

    assign idle            = (cnt == '0);
    assign retire_valid    = !idle;
    assign retire_reg      = idle ? '0 : mem[rd_ptr].rd;
    assign retire_reg_data = idle ? '0 : mem[rd_ptr].dat;
    assign count           = cnt;

    always_comb begin
        pending_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (i < int'(cnt)) pending_mask[mem[rd_ptr + PTR_W'(i)].rd] = 1'b1;
        end
    end

    cnt_bound: assert property (@(posedge clk) disable iff (!rst) cnt <= CNT_W'(DEPTH));
endmodule

// File: tb/tb_arf_retire_sched.sv
// Randomized and directed bench for arf_retire_sched against a queue-based model.
module tb_arf_retire_sched;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        lane0_valid = 1'b0;
    logic [4:0]  lane0_reg = '0;
    logic [31:0] lane0_data = '0;
    logic        lane1_valid = 1'b0;
    logic [4:0]  lane1_reg = '0;
    logic [31:0] lane1_data = '0;
    logic        in_ready;
    logic        retire_valid;
    logic [4:0]  retire_reg;
    logic [31:0] retire_reg_data;
    logic [31:0] pending_mask;
    logic [2:0]  count;
    logic        idle;

    arf_retire_sched dut (
        .clk(clk), .rst(rst),
        .lane0_valid(lane0_valid), .lane0_reg(lane0_reg), .lane0_data(lane0_data),
        .lane1_valid(lane1_valid), .lane1_reg(lane1_reg), .lane1_data(lane1_data),
        .in_ready(in_ready), .retire_valid(retire_valid), .retire_reg(retire_reg),
        .retire_reg_data(retire_reg_data), .pending_mask(pending_mask),
        .count(count), .idle(idle)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    function automatic void check(string nm, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endfunction

    typedef struct {
        logic [4:0]  r;
        logic [31:0] d;
    } ent_t;

    // Model: a plain queue; each edge drops the head if any, then appends the
    // nonzero-register lanes if there was room for two before the edge.
    ent_t mq[$];
    bit   mrdy;
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mq.delete();
        end else begin
            mrdy = (mq.size() <= DEPTH - 2);
            if (mq.size() > 0) void'(mq.pop_front());
            if (mrdy) begin
                if (lane0_valid && lane0_reg != 0) mq.push_back('{lane0_reg, lane0_data});
                if (lane1_valid && lane1_reg != 0) mq.push_back('{lane1_reg, lane1_data});
            end
        end
    end

    logic [31:0] exp_mask;
    always @(negedge clk) begin
        exp_mask = '0;
        foreach (mq[i]) exp_mask[mq[i].r] = 1'b1;
        check("cmp_retire_valid", retire_valid, mq.size() != 0);
        check("cmp_retire_reg", retire_reg, mq.size() != 0 ? mq[0].r : 5'd0);
        check("cmp_retire_data", retire_reg_data, mq.size() != 0 ? mq[0].d : 32'd0);
        check("cmp_count", count, mq.size());
        check("cmp_idle", idle, mq.size() == 0);
        check("cmp_in_ready", in_ready, mq.size() <= DEPTH - 2);
        check("cmp_pending_mask", pending_mask, exp_mask);
    end

    task automatic drive(bit v0, logic [4:0] r0, logic [31:0] d0,
                         bit v1, logic [4:0] r1, logic [31:0] d1);
        lane0_valid = v0; lane0_reg = r0; lane0_data = d0;
        lane1_valid = v1; lane1_reg = r1; lane1_data = d1;
    endtask

    task automatic clr();
        drive(0, 0, 0, 0, 0, 0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    logic [31:0] got[$];
    int n, first, last, cyc;
    bit acc;

    initial begin
        rst = 1'b0;
        clr();
        repeat (3) @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_idle", idle, 1);
        check("rst_count", count, 0);
        check("rst_retire_valid", retire_valid, 0);
        check("rst_mask", pending_mask, 0);

        // Single lane0 write; push on the first edge after release.
        @(posedge clk); #1;
        rst = 1'b1;
        drive(1, 5, 32'hDEADBEEF, 0, 0, 0);
        step(); clr();
        @(negedge clk);
        check("s1_valid", retire_valid, 1);
        check("s1_reg", retire_reg, 5);
        check("s1_data", retire_reg_data, 32'hDEADBEEF);
        check("s1_mask5", pending_mask[5], 1);
        step();
        @(negedge clk);
        check("s1_idle", idle, 1);

        // Both lanes to reg 3, lane0 first.
        drive(1, 3, 32'h11, 1, 3, 32'h22);
        step(); clr();
        @(negedge clk);
        check("s2_data0", retire_reg_data, 32'h11);
        check("s2_count", count, 2);
        check("s2_mask3a", pending_mask[3], 1);
        step();
        @(negedge clk);
        check("s2_data1", retire_reg_data, 32'h22);
        check("s2_mask3b", pending_mask[3], 1);
        step();
        @(negedge clk);
        check("s2_idle", idle, 1);

        // lane0 targets r0 and is dropped.
        drive(1, 0, 32'hAA, 1, 7, 32'h77);
        step(); clr();
        @(negedge clk);
        check("s3_count", count, 1);
        check("s3_reg", retire_reg, 7);
        check("s3_data", retire_reg_data, 32'h77);
        step();
        @(negedge clk);
        check("s3_count_after", count, 0);

        // Push 2 at count 2 alongside a pop.
        drive(1, 9, 32'h1, 1, 10, 32'h2);
        step();
        drive(1, 11, 32'h3, 1, 12, 32'h4);
        @(negedge clk);
        check("s6_count2", count, 2);
        check("s6_ready2", in_ready, 1);
        step(); clr();
        @(negedge clk);
        check("s6_count3", count, 3);
        check("s6_ready3", in_ready, 0);

        // Async reset mid-cycle with three queued entries.
        #2 rst = 1'b0;
        #1;
        check("s5_valid", retire_valid, 0);
        check("s5_count", count, 0);
        check("s5_idle", idle, 1);
        check("s5_mask", pending_mask, 0);
        check("s5_ready", in_ready, 1);
        check("s5_reg", retire_reg, 0);
        check("s5_data", retire_reg_data, 0);
        step(); step();
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("s5_no_stale", retire_valid, 0);
        end

        // Continuous 2-wide stream of 20 entries.
        step();
        n = 0; first = -1; last = -1; cyc = 0;
        got.delete();
        drive(1, 5'(n % 14 + 1), 32'(100 + n), 1, 5'((n + 1) % 14 + 1), 32'(101 + n));
        for (int g = 0; g < 100 && got.size() < 20; g++) begin
            @(negedge clk);
            if (retire_valid) begin
                if (first < 0) first = cyc;
                last = cyc;
                got.push_back(retire_reg_data);
            end
            acc = in_ready;
            cyc++;
            step();
            if (acc && n < 20) begin
                n += 2;
                if (n < 20) drive(1, 5'(n % 14 + 1), 32'(100 + n), 1, 5'((n + 1) % 14 + 1), 32'(101 + n));
                else clr();
            end
        end
        check("s4_n_writes", got.size(), 20);
        check("s4_span", last - first, 19);
        for (int i = 0; i < got.size(); i++) check("s4_order", got[i], 32'(100 + i));

        // Random traffic with hold-until-accepted producers and one async reset.
        clr();
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            acc = in_ready;
            if (i == 300) begin
                #2 rst = 1'b0;
                step();
                rst = 1'b1;
                acc = 1'b1;
            end else begin
                step();
            end
            if (acc || !(lane0_valid || lane1_valid)) begin
                drive($urandom_range(0, 3) != 0,
                      ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
                      $urandom,
                      $urandom_range(0, 3) != 0,
                      ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
                      $urandom);
            end
        end
        clr();
        repeat (6) step();
        @(negedge clk);
        check("end_idle", idle, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
